// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: serially scans VOICES slots per note event, then
// commits a note-on (retrigger / free / steal-oldest) or note-off to one slot.
module voice_alloc #(
  parameter int VOICES = 4,
  parameter int IDX_W  = 2,
  parameter int AGE_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  ev_valid,
  output logic                  ev_ready,
  input  logic                  ev_on,
  input  logic [6:0]            ev_note,
  input  logic [6:0]            ev_vel,
  input  logic                  all_off,
  output logic [VOICES*7-1:0]   voice_note,
  output logic [VOICES*7-1:0]   voice_vel,
  output logic [VOICES-1:0]     voice_gate,
  output logic                  stole
);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic               lat_on;
  logic [6:0]         lat_note;
  logic [6:0]         lat_vel;
  logic               match_found, free_found, oldest_found;
  logic [IDX_W-1:0]   match_idx, free_idx, oldest_idx;
  logic [AGE_W-1:0]   oldest_age;

  logic [6:0]         note_q [VOICES];
  logic [6:0]         vel_q  [VOICES];
  logic               gate_q [VOICES];
  logic [AGE_W-1:0]   age_q  [VOICES];

  logic [IDX_W-1:0]   tgt_idx;
  logic               steal;

  function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
    return (a == {AGE_W{1'b1}}) ? a : a + AGE_W'(1);
  endfunction

  assign ev_ready = (state == IDLE) && !rst;

  // Note-on target priority: retrigger matching slot, then lowest free, then steal oldest.
  always_comb begin
    steal   = !match_found && !free_found;
    tgt_idx = match_found ? match_idx : (free_found ? free_idx : oldest_idx);
  end

  always_comb begin
    voice_note = '0;
    voice_vel  = '0;
    voice_gate = '0;
    for (int i = 0; i < VOICES; i++) begin
      voice_note[7*i +: 7] = note_q[i];
      voice_vel[7*i +: 7]  = vel_q[i];
      voice_gate[i]        = gate_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      lat_on       <= 1'b0;
      lat_note     <= '0;
      lat_vel      <= '0;
      match_found  <= 1'b0;
      free_found   <= 1'b0;
      oldest_found <= 1'b0;
      match_idx    <= '0;
      free_idx     <= '0;
      oldest_idx   <= '0;
      oldest_age   <= '0;
      stole        <= 1'b0;
      for (int i = 0; i < VOICES; i++) begin
        note_q[i] <= '0;
        vel_q[i]  <= '0;
        gate_q[i] <= 1'b0;
        age_q[i]  <= '0;
      end
    end else if (ce) begin
      stole <= 1'b0;
      case (state)
        IDLE: begin
          if (all_off) begin
            for (int i = 0; i < VOICES; i++) begin
              gate_q[i] <= 1'b0;
              age_q[i]  <= '0;
            end
          end else if (ev_valid) begin
            lat_on       <= ev_on && (ev_vel != 7'd0);
            lat_note     <= ev_note;
            lat_vel      <= ev_vel;
            idx          <= '0;
            match_found  <= 1'b0;
            free_found   <= 1'b0;
            oldest_found <= 1'b0;
            oldest_age   <= '0;
            state        <= SCAN;
          end
        end
        SCAN: begin
          if (gate_q[idx] && (note_q[idx] == lat_note) && !match_found) begin
            match_found <= 1'b1;
            match_idx   <= idx;
          end
          if (!gate_q[idx] && !free_found) begin
            free_found <= 1'b1;
            free_idx   <= idx;
          end
          // Strict compare keeps the lowest index on an age tie.
          if (gate_q[idx] && (!oldest_found || (age_q[idx] > oldest_age))) begin
            oldest_found <= 1'b1;
            oldest_idx   <= idx;
            oldest_age   <= age_q[idx];
          end
          if (idx == IDX_W'(VOICES - 1)) state <= COMMIT;
          else                           idx   <= idx + IDX_W'(1);
        end
        COMMIT: begin
          if (lat_on) begin
            for (int i = 0; i < VOICES; i++) begin
              if (IDX_W'(i) == tgt_idx) begin
                note_q[i] <= lat_note;
                vel_q[i]  <= lat_vel;
                gate_q[i] <= 1'b1;
                age_q[i]  <= '0;
              end else if (gate_q[i]) begin
                age_q[i] <= age_inc(age_q[i]);
              end
            end
            stole <= steal;
          end else if (match_found) begin
            gate_q[match_idx] <= 1'b0;
            vel_q[match_idx]  <= '0;
            age_q[match_idx]  <= '0;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_alloc.sv
// Bench for voice_alloc: directed scenarios plus random event streams checked
// against a slot-level behavioural model.
module tb_voice_alloc;
  localparam int V  = 4;
  localparam int AW = 4;
  localparam int AGE_MAX = (1 << AW) - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           ce = 1'b1;
  logic           ev_valid = 1'b0;
  logic           ev_ready;
  logic           ev_on = 1'b0;
  logic [6:0]     ev_note = '0;
  logic [6:0]     ev_vel = '0;
  logic           all_off = 1'b0;
  logic [V*7-1:0] voice_note;
  logic [V*7-1:0] voice_vel;
  logic [V-1:0]   voice_gate;
  logic           stole;

  int n_checks = 0;
  int n_fail = 0;

  int         m_note [V];
  int         m_vel  [V];
  bit         m_gate [V];
  int         m_age  [V];
  bit         exp_stole;

  voice_alloc #(.VOICES(V), .IDX_W(2), .AGE_W(AW)) dut (
    .clk(clk), .rst(rst), .ce(ce), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_on(ev_on), .ev_note(ev_note), .ev_vel(ev_vel), .all_off(all_off),
    .voice_note(voice_note), .voice_vel(voice_vel), .voice_gate(voice_gate), .stole(stole)
  );

  always #5 clk = ~clk;

  function automatic void model_clear();
    for (int i = 0; i < V; i++) begin
      m_note[i] = 0; m_vel[i] = 0; m_gate[i] = 0; m_age[i] = 0;
    end
    exp_stole = 0;
  endfunction

  function automatic void model_all_off();
    for (int i = 0; i < V; i++) begin
      m_gate[i] = 0; m_age[i] = 0;
    end
  endfunction

  function automatic void model_event(input bit on, input int n, input int v);
    int match = -1;
    int free = -1;
    int old = -1;
    int t;
    for (int i = 0; i < V; i++) if (m_gate[i] && m_note[i] == n && match < 0) match = i;
    for (int i = 0; i < V; i++) if (!m_gate[i] && free < 0) free = i;
    for (int i = 0; i < V; i++) if (m_gate[i] && (old < 0 || m_age[i] > m_age[old])) old = i;
    exp_stole = 0;
    if (on && v != 0) begin
      t = (match >= 0) ? match : ((free >= 0) ? free : old);
      exp_stole = (match < 0 && free < 0);
      for (int i = 0; i < V; i++)
        if (i != t && m_gate[i] && m_age[i] < AGE_MAX) m_age[i]++;
      m_note[t] = n; m_vel[t] = v; m_gate[t] = 1; m_age[t] = 0;
    end else if (match >= 0) begin
      m_gate[match] = 0; m_vel[match] = 0; m_age[match] = 0;
    end
  endfunction

  function automatic logic [V*15-1:0] exp_vec();
    logic [V*7-1:0] en, ev;
    logic [V-1:0]   eg;
    for (int i = 0; i < V; i++) begin
      en[7*i +: 7] = 7'(m_note[i]);
      ev[7*i +: 7] = 7'(m_vel[i]);
      eg[i]        = m_gate[i];
    end
    return {eg, ev, en};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_event(input bit on, input int n, input int v);
    @(negedge clk);
    ev_valid = 1'b1; ev_on = on; ev_note = 7'(n); ev_vel = 7'(v);
    @(posedge clk);
    #1 ev_valid = 1'b0;
  endtask

  // Drives one event through to its commit edge and updates the model; samples #1 later.
  task automatic do_event(input bit on, input int n, input int v);
    start_event(on, n, v);
    repeat (V + 1) @(posedge clk);
    #1 model_event(on, n, v);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (ev_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low got=%b exp=0", ev_ready); end
    n_checks++;
    if ({voice_gate, voice_vel, voice_note} !== exp_vec() || stole !== 1'b0) begin
      n_fail++; $display("FAIL reset_slots got=%h stole=%b exp=%h stole=0", {voice_gate, voice_vel, voice_note}, stole, exp_vec());
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (ev_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_release got=%b exp=1", ev_ready); end
  endtask

  task automatic test_basic();
    do_reset();
    start_event(1, 60, 100);
    n_checks++;
    if (ev_ready !== 1'b0) begin n_fail++; $display("FAIL busy_ready got=%b exp=0", ev_ready); end
    repeat (V) @(posedge clk);
    #1;
    n_checks++;
    if ({voice_gate, voice_vel, voice_note} !== exp_vec()) begin
      n_fail++; $display("FAIL basic_early got=%h exp=%h", {voice_gate, voice_vel, voice_note}, exp_vec());
    end
    @(posedge clk);
    #1 model_event(1, 60, 100);
    n_checks++;
    if ({voice_gate, voice_vel, voice_note} !== exp_vec() || stole !== 1'b0 || ev_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_on got=%h stole=%b rdy=%b exp=%h stole=0 rdy=1", {voice_gate, voice_vel, voice_note}, stole, ev_ready, exp_vec());
    end
  endtask

  task automatic test_steal();
    int notes [5] = '{60, 62, 64, 65, 67};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      do_event(1, notes[k], 80 + k);
      n_checks++;
      if ({voice_gate, voice_vel, voice_note} !== exp_vec() || stole !== exp_stole) begin
        n_fail++; $display("FAIL steal_seq%0d got=%h stole=%b exp=%h stole=%b", k, {voice_gate, voice_vel, voice_note}, stole, exp_vec(), exp_stole);
      end
    end
    n_checks++;
    if (voice_note[6:0] !== 7'd67 || stole !== 1'b1) begin
      n_fail++; $display("FAIL steal_slot0 got note=%0d stole=%b exp note=67 stole=1", voice_note[6:0], stole);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (stole !== 1'b0) begin n_fail++; $display("FAIL steal_pulse got=%b exp=0", stole); end
  endtask

  task automatic test_note_off();
    do_reset();
    do_event(1, 60, 70);
    do_event(1, 60, 0);
    n_checks++;
    if ({voice_gate, voice_vel, voice_note} !== exp_vec() || voice_note[6:0] !== 7'd60 || voice_gate[0] !== 1'b0) begin
      n_fail++; $display("FAIL vel0_off got=%h exp=%h", {voice_gate, voice_vel, voice_note}, exp_vec());
    end
    do_event(1, 61, 50);
    do_event(0, 63, 0);
    n_checks++;
    if ({voice_gate, voice_vel, voice_note} !== exp_vec()) begin
      n_fail++; $display("FAIL off_nomatch got=%h exp=%h", {voice_gate, voice_vel, voice_note}, exp_vec());
    end
  endtask

  task automatic test_retrigger();
    do_reset();
    do_event(1, 60, 50);
    do_event(1, 60, 90);
    n_checks++;
    if ({voice_gate, voice_vel, voice_note} !== exp_vec() || voice_vel[6:0] !== 7'd90 || voice_gate[1] !== 1'b0) begin
      n_fail++; $display("FAIL retrigger got=%h exp=%h", {voice_gate, voice_vel, voice_note}, exp_vec());
    end
  endtask

  task automatic test_all_off();
    do_reset();
    do_event(1, 40, 10);
    do_event(1, 41, 20);
    @(negedge clk);
    all_off = 1'b1; ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd50; ev_vel = 7'd30;
    @(posedge clk);
    #1 all_off = 1'b0; ev_valid = 1'b0;
    model_all_off();
    n_checks++;
    if ({voice_gate, voice_vel, voice_note} !== exp_vec() || ev_ready !== 1'b1) begin
      n_fail++; $display("FAIL all_off got=%h rdy=%b exp=%h rdy=1", {voice_gate, voice_vel, voice_note}, ev_ready, exp_vec());
    end
    repeat (V + 2) @(posedge clk);
    #1;
    n_checks++;
    if ({voice_gate, voice_vel, voice_note} !== exp_vec()) begin
      n_fail++; $display("FAIL all_off_noaccept got=%h exp=%h", {voice_gate, voice_vel, voice_note}, exp_vec());
    end
    do_event(1, 42, 5);
    n_checks++;
    if ({voice_gate, voice_vel, voice_note} !== exp_vec()) begin
      n_fail++; $display("FAIL after_all_off got=%h exp=%h", {voice_gate, voice_vel, voice_note}, exp_vec());
    end
  endtask

  task automatic test_reset_mid_scan();
    do_reset();
    do_event(1, 60, 100);
    start_event(1, 62, 90);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    model_clear();
    #1;
    n_checks++;
    if ({voice_gate, voice_vel, voice_note} !== exp_vec() || ev_ready !== 1'b0 || stole !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid got=%h rdy=%b exp=%h rdy=0", {voice_gate, voice_vel, voice_note}, ev_ready, exp_vec());
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (V + 3) @(posedge clk);
    #1;
    n_checks++;
    if ({voice_gate, voice_vel, voice_note} !== exp_vec() || ev_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_after got=%h rdy=%b exp=%h rdy=1", {voice_gate, voice_vel, voice_note}, ev_ready, exp_vec());
    end
  endtask

  task automatic test_ce_hold();
    do_reset();
    do_event(1, 60, 100);
    start_event(1, 62, 90);
    repeat (2) @(posedge clk);
    @(negedge clk);
    ce = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({voice_gate, voice_vel, voice_note} !== exp_vec() || ev_ready !== 1'b0) begin
      n_fail++; $display("FAIL ce_hold got=%h rdy=%b exp=%h rdy=0", {voice_gate, voice_vel, voice_note}, ev_ready, exp_vec());
    end
    @(negedge clk);
    ce = 1'b1;
    repeat (V - 2) @(posedge clk);
    #1;
    n_checks++;
    if ({voice_gate, voice_vel, voice_note} !== exp_vec()) begin
      n_fail++; $display("FAIL ce_early got=%h exp=%h", {voice_gate, voice_vel, voice_note}, exp_vec());
    end
    @(posedge clk);
    #1 model_event(1, 62, 90);
    n_checks++;
    if ({voice_gate, voice_vel, voice_note} !== exp_vec() || ev_ready !== 1'b1) begin
      n_fail++; $display("FAIL ce_resume got=%h rdy=%b exp=%h rdy=1", {voice_gate, voice_vel, voice_note}, ev_ready, exp_vec());
    end
  endtask

  task automatic test_random();
    int n, v;
    bit on;
    do_reset();
    for (int k = 0; k < 120; k++) begin
      if ($urandom_range(0, 19) == 0) begin
        @(negedge clk);
        all_off = 1'b1; ev_valid = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1 all_off = 1'b0; ev_valid = 1'b0;
        model_all_off();
      end else begin
        on = ($urandom_range(0, 3) != 0);
        n  = 60 + $urandom_range(0, 7);
        v  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 127);
        do_event(on, n, v);
      end
      n_checks++;
      if ({voice_gate, voice_vel, voice_note} !== exp_vec() || stole !== exp_stole) begin
        n_fail++; $display("FAIL random%0d got=%h stole=%b exp=%h stole=%b", k, {voice_gate, voice_vel, voice_note}, stole, exp_vec(), exp_stole);
      end
      exp_stole = 0;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_steal();
    test_note_off();
    test_retrigger();
    test_all_off();
    test_reset_mid_scan();
    test_ce_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
